mult_acc_stage: RTL
===================

MULT_ACC_STAGE -- requirements
Module: mult_acc_stage

Interface
REQ-001 SHALL have parameter LEN, default 4: number of products summed per frame; legal range 1..16.
REQ-002 SHALL have parameter ACC_W, default 16: accumulator width; 16 holds 63*63*16 = 63504 without overflow.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: operand pair on in_x/in_y is valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts an operand pair this cycle.
REQ-007 SHALL have ports in_x and in_y, input, 6 each: unsigned operands.
REQ-008 SHALL have ports mul_x and mul_y, output, 6 each: registered operands driven to the external 6x6 combinational multiplier.
REQ-009 SHALL have port prdct_in, input, 12: unsigned product returned by that multiplier in the same cycle.
REQ-010 SHALL have port out_valid, output, 1: acc_out holds a completed frame sum.
REQ-011 SHALL have port out_ready, input, 1: downstream takes the result.
REQ-012 SHALL have port acc_out, output, ACC_W: accumulator value.
REQ-013 SHALL have port frame_cnt, output, 5: products accumulated in the current frame.

Function
REQ-014 SHALL implement FSM states IDLE, ACC and DONE.
REQ-015 SHALL assert in_ready in IDLE, and in ACC while accepted-operand count < LEN; it SHALL deassert in_ready in DONE.
REQ-016 SHALL treat each cycle with in_valid=1 and in_ready=1 as an accept: on that edge mul_x<=in_x, mul_y<=in_y, pvld<=1 and the accepted count increments; otherwise pvld<=0 and mul_x/mul_y hold.
REQ-017 SHALL, on any edge where pvld=1, set acc_out<=acc_out+zero-extended prdct_in and increment frame_cnt; the product is therefore summed exactly one edge after its accept.
REQ-018 SHALL transition IDLE->ACC on the first accept of a frame.
REQ-019 SHALL transition ACC->DONE on the edge where pvld=1 and frame_cnt+1==LEN; out_valid SHALL rise on that same edge with acc_out already holding the final sum.
REQ-020 SHALL, for LEN=1, go IDLE->ACC on the accept and ACC->DONE one edge later.
REQ-021 SHALL, in DONE, hold out_valid, acc_out and frame_cnt stable until out_ready=1.
REQ-022 SHALL, on a DONE edge with out_ready=1, clear acc_out, frame_cnt and the accepted count, deassert out_valid and enter IDLE; in_ready SHALL return to 1 in the following cycle.
REQ-023 SHALL ignore in_valid whenever in_ready=0: no register changes and no loss of an already accepted pair.
REQ-024 SHALL ignore out_ready while out_valid=0.
REQ-025 SHALL have no combinational path from in_valid or out_ready to any output; in_ready and out_valid SHALL be functions of state and counters only.
REQ-026 SHALL not saturate; sums are bounded by the LEN range in REQ-001.

Reset
REQ-027 SHALL, while rst_n=0, immediately force: state IDLE, in_ready=1 (after release), out_valid=0, acc_out=0, frame_cnt=0, mul_x=0, mul_y=0, pvld=0, accepted count 0.
REQ-028 SHALL, on reset asserted mid-frame or in DONE, discard the partial or pending sum; the first accept after release starts a new frame.

Verification
REQ-029 LEN=4, pairs (63,63),(1,1),(0,5),(2,3) back-to-back -> out_valid rises one edge after the 4th accept, acc_out=3969+1+0+6=3976, frame_cnt=4, in_ready=0.
REQ-030 Same frame with gaps of 0..3 idle cycles between accepts -> identical acc_out=3976; mul_x/mul_y hold during gaps.
REQ-031 Result held with out_ready=0 for 5 cycles, with in_valid=1 throughout -> acc_out stays 3976 and no operand is accepted; out_ready=1 -> next cycle acc_out=0, out_valid=0, in_ready=1.
REQ-032 LEN=16, sixteen pairs (63,63) -> acc_out=63504, no wrap.
REQ-033 rst_n pulsed low after the 2nd accept of a frame -> all outputs 0 at once; the next 4 pairs (1,1) yield acc_out=4.
REQ-034 LEN=1, pair (7,9) -> out_valid one edge after the accept with acc_out=63; a random-operand scoreboard of 1000 frames matches the reference sum.

Source files
------------

// File: rtl/mult_acc_stage.sv
// mult_acc_stage: frame-based multiply-accumulate front end.
// Operand pairs are accepted with a valid/ready handshake and registered
// onto mul_x/mul_y, which feed an external combinational 6x6 multiplier.
// The returned product is summed one edge after its accept. After LEN
// products the completed sum is presented on acc_out with out_valid, and it
// stays there until downstream takes it with out_ready.
module mult_acc_stage #(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_x,
  input  logic [5:0]       in_y,
  output logic [5:0]       mul_x,
  output logic [5:0]       mul_y,
  input  logic [11:0]      prdct_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [4:0]       frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  localparam logic [4:0] LEN_C = 5'(LEN);

  state_t     state;
  logic       pvld;        // mul_x/mul_y hold a pair accepted on the last edge
  logic [4:0] accept_cnt;  // operand pairs accepted in the current frame
  logic       accept;

  // Ready depends only on state and the accept counter, so neither
  // handshake input reaches an output combinationally.
  assign in_ready = (state == IDLE) || ((state == ACC) && (accept_cnt < LEN_C));
  assign accept   = in_valid && in_ready;

  // Operand capture, delayed accumulation and frame sequencing.
  // NOTE: every register here resets asynchronously and is updated with
  // non-blocking assignments, so all of them see pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      pvld       <= 1'b0;
      accept_cnt <= '0;
      mul_x      <= '0;
      mul_y      <= '0;
      acc_out    <= '0;
      frame_cnt  <= '0;
    end else begin
      pvld <= accept;

      if (accept) begin
        mul_x      <= in_x;
        mul_y      <= in_y;
        accept_cnt <= accept_cnt + 5'd1;
      end

      // The product of the pair registered last edge is valid this cycle.
      if (pvld) begin
        acc_out   <= acc_out + ACC_W'(prdct_in);
        frame_cnt <= frame_cnt + 5'd1;
      end

      case (state)
        IDLE: begin
          if (accept) state <= ACC;
        end
        ACC: begin
          // Last product lands on this edge, so acc_out is final with out_valid.
          if (pvld && (frame_cnt + 5'd1 == LEN_C)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // pvld is always 0 here: the last product was summed on entry.
          if (out_ready) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            acc_out    <= '0;
            frame_cnt  <= '0;
            accept_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
